dtrig_axil_master: RTL

AXI-Lite master that drives the trigger register slave of the DRS write-trigger block. It turns single-word commands from local control logic (bench sequencer, run controller or PS-less test harness) into AXI-Lite write or read transactions. It returns one response per command, with a bounded-wait timeout. It sits on the initiator side of the same AXI-Lite link the trigger slave responds on. It uses the reduced signal set of that link: no PROT, no BRESP/RRESP.

---
 rtl/dtrig_axil_master.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/dtrig_axil_master.sv
// dtrig_axil_master: AXI-Lite master that turns single-word commands into trigger-slave transactions.
// Optional macro DTRIG_MASTER_READBACK_EN: follow every write with a read-back of the same address.
module dtrig_axil_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_SIZE      = 32,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_rnw,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_SIZE-1:0]  cmd_data,
    output logic                  rsp_valid,
    output logic [DATA_SIZE-1:0]  rsp_data,
    output logic                  rsp_timeout,
    output logic                  rsp_mismatch,
    output logic [ADDR_WIDTH-1:0] M_AXI_LITE_AWADDR,
    output logic                  M_AXI_LITE_AWVALID,
    input  logic                  M_AXI_LITE_AWREADY,
    output logic [DATA_SIZE-1:0]  M_AXI_LITE_WDATA,
    output logic                  M_AXI_LITE_WVALID,
    input  logic                  M_AXI_LITE_WREADY,
    input  logic                  M_AXI_LITE_BVALID,
    output logic                  M_AXI_LITE_BREADY,
    output logic [ADDR_WIDTH-1:0] M_AXI_LITE_ARADDR,
    output logic                  M_AXI_LITE_ARVALID,
    input  logic                  M_AXI_LITE_ARREADY,
    input  logic [DATA_SIZE-1:0]  M_AXI_LITE_RDATA,
    input  logic                  M_AXI_LITE_RVALID,
    output logic                  M_AXI_LITE_RREADY
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WRESP,
        ST_RADDR,
        ST_RDATA,
        ST_DONE
    } state_t;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t                r_state;
    logic                  r_cmdReady;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_bready;
    logic                  r_arvalid;
    logic                  r_rready;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_SIZE-1:0]  r_wdata;
    logic [DATA_SIZE-1:0]  r_rspData;
    logic                  r_rspValid;
    logic                  r_rspTimeout;
    logic [15:0]           r_waitCnt;
    logic                  w_awDone;
    logic                  w_wDone;
    logic                  w_timeUp;
`ifdef DTRIG_MASTER_READBACK_EN
    logic                  r_isWrite;
    logic                  r_rspMismatch;
`endif

    // A write channel counts as done if it already handshook or is handshaking this cycle.
    assign w_awDone = !r_awvalid || M_AXI_LITE_AWREADY;
    assign w_wDone  = !r_wvalid  || M_AXI_LITE_WREADY;
    assign w_timeUp = (r_waitCnt == TIMEOUT_LIMIT);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state      <= ST_IDLE;
            r_cmdReady   <= 1'b1;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rspData    <= '0;
            r_rspValid   <= 1'b0;
            r_rspTimeout <= 1'b0;
            r_waitCnt    <= '0;
`ifdef DTRIG_MASTER_READBACK_EN
            r_isWrite     <= 1'b0;
            r_rspMismatch <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_cmdReady <= 1'b0;
                        r_addr     <= cmd_addr;
                        r_waitCnt  <= '0;
`ifdef DTRIG_MASTER_READBACK_EN
                        r_isWrite  <= !cmd_rnw;
`endif
                        if (cmd_rnw) begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_RADDR;
                        end else begin
                            r_wdata   <= cmd_data;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= ST_WR;
                        end
                    end
                end
                ST_WR: begin
                    if (w_awDone && w_wDone) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b0;
                        r_bready  <= 1'b1;
                        r_waitCnt <= '0;
                        r_state   <= ST_WRESP;
                    end else if (w_timeUp) begin
                        r_awvalid    <= 1'b0;
                        r_wvalid     <= 1'b0;
                        r_rspValid   <= 1'b1;
                        r_rspTimeout <= 1'b1;
                        r_rspData    <= '0;
                        r_state      <= ST_DONE;
                    end else begin
                        if (M_AXI_LITE_AWREADY) r_awvalid <= 1'b0;
                        if (M_AXI_LITE_WREADY)  r_wvalid  <= 1'b0;
                        r_waitCnt <= r_waitCnt + 16'd1;
                    end
                end
                ST_WRESP: begin
                    if (M_AXI_LITE_BVALID) begin
                        r_bready <= 1'b0;
`ifdef DTRIG_MASTER_READBACK_EN
                        r_arvalid <= 1'b1;
                        r_waitCnt <= '0;
                        r_state   <= ST_RADDR;
`else
                        r_rspValid <= 1'b1;
                        r_rspData  <= '0;
                        r_state    <= ST_DONE;
`endif
                    end else if (w_timeUp) begin
                        r_bready     <= 1'b0;
                        r_rspValid   <= 1'b1;
                        r_rspTimeout <= 1'b1;
                        r_rspData    <= '0;
                        r_state      <= ST_DONE;
                    end else begin
                        r_waitCnt <= r_waitCnt + 16'd1;
                    end
                end
                ST_RADDR: begin
                    if (M_AXI_LITE_ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_waitCnt <= '0;
                        r_state   <= ST_RDATA;
                    end else if (w_timeUp) begin
                        r_arvalid    <= 1'b0;
                        r_rspValid   <= 1'b1;
                        r_rspTimeout <= 1'b1;
                        r_rspData    <= '0;
                        r_state      <= ST_DONE;
                    end else begin
                        r_waitCnt <= r_waitCnt + 16'd1;
                    end
                end
                ST_RDATA: begin
                    if (M_AXI_LITE_RVALID) begin
                        r_rready   <= 1'b0;
                        r_rspValid <= 1'b1;
                        r_rspData  <= M_AXI_LITE_RDATA;
`ifdef DTRIG_MASTER_READBACK_EN
                        r_rspMismatch <= r_isWrite && (M_AXI_LITE_RDATA != r_wdata);
`endif
                        r_state    <= ST_DONE;
                    end else if (w_timeUp) begin
                        r_rready     <= 1'b0;
                        r_rspValid   <= 1'b1;
                        r_rspTimeout <= 1'b1;
                        r_rspData    <= '0;
                        r_state      <= ST_DONE;
                    end else begin
                        r_waitCnt <= r_waitCnt + 16'd1;
                    end
                end
                ST_DONE: begin
                    r_rspValid   <= 1'b0;
                    r_rspTimeout <= 1'b0;
                    r_rspData    <= '0;
                    r_cmdReady   <= 1'b1;
`ifdef DTRIG_MASTER_READBACK_EN
                    r_rspMismatch <= 1'b0;
`endif
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready          = r_cmdReady;
    assign rsp_valid          = r_rspValid;
    assign rsp_data           = r_rspData;
    assign rsp_timeout        = r_rspTimeout;
    assign M_AXI_LITE_AWADDR  = r_addr;
    assign M_AXI_LITE_AWVALID = r_awvalid;
    assign M_AXI_LITE_WDATA   = r_wdata;
    assign M_AXI_LITE_WVALID  = r_wvalid;
    assign M_AXI_LITE_BREADY  = r_bready;
    assign M_AXI_LITE_ARADDR  = r_addr;
    assign M_AXI_LITE_ARVALID = r_arvalid;
    assign M_AXI_LITE_RREADY  = r_rready;
`ifdef DTRIG_MASTER_READBACK_EN
    assign rsp_mismatch = r_rspMismatch;
`else
    assign rsp_mismatch = 1'b0;
`endif

endmodule
